lsu_mem_arbiter: RTL and testbench
==================================

Name: lsu_mem_arbiter

Overview:
- Arbitrates a single data-memory/IO bus between two requesters:
  - port 0: the pipeline MEM stage (load/store from the EX_MEM register).
  - port 1: a loader/debug master that preloads or inspects memory.
- Sequences one outstanding transaction at a time.
- Drives a stall back to the pipeline while its access is pending.
- Guarantees port 1 forward progress with a starvation counter.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory bus.
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, consecutive port-0 wins tolerated while port 1 waits (1..255).
- TIMEOUT_CYC, 255, response watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- p0_req_i  in  1  pipeline request, level-held until p0_rvalid_o.
- p0_we_i  in  1  pipeline write enable.
- p0_addr_i  in  ADDR_W  pipeline address.
- p0_wdata_i  in  DATA_W  pipeline write data.
- p0_rvalid_o  out  1  one-cycle completion pulse to pipeline.
- p0_rdata_o  out  DATA_W  read data, valid with p0_rvalid_o.
- stall_o  out  1  freeze IF/ID/EX/MEM while the port-0 access is incomplete.
- p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_rvalid_o, p1_rdata_o: same as port 0, for the loader.
- mem_req_o  out  1  request to memory.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_ready_i  in  1  memory accepts the request this cycle.
- mem_rvalid_i  in  1  memory response (read data or write ack).
- mem_rdata_i  in  DATA_W  memory read data.
- err_o  out  1  sticky timeout error (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (async, rst_ni=0): FSM=IDLE; all outputs 0; starvation count 0; owner 0.
- States: IDLE -> ISSUE -> WAIT_RSP -> IDLE.
- IDLE:
  - If any request is present, select the owner and latch we/addr/wdata from that port into internal registers.
  - Go to ISSUE next cycle.
  - No combinational request-to-memory path.
- Selection:
  - Port 0 wins by default.
  - Port 1 wins if only p1 requests, or if the starvation count = STARVE_LIMIT.
- Starvation count:
  - Increments when port 0 wins while p1_req_i=1.
  - Clears when port 1 wins, or when p1_req_i=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- ISSUE:
  - mem_req_o=1; mem_we/addr/wdata driven from the latched registers.
  - Held until mem_ready_i=1, then go to WAIT_RSP.
  - If mem_ready_i and mem_rvalid_i arrive in the same cycle, complete immediately and go to IDLE.
- WAIT_RSP:
  - mem_req_o=0.
  - On mem_rvalid_i, pulse the owner's pN_rvalid_o for exactly one cycle.
  - pN_rdata_o is registered from mem_rdata_i.
  - Go to IDLE.
- Writes also wait for mem_rvalid_i (ack). rdata is don't-care for writes.
- stall_o = p0_req_i and not p0_rvalid_o.
  - Asserted combinationally the same cycle p0_req_i rises.
  - Low in the p0_rvalid_o cycle, so the pipeline advances on that edge.
- Minimum latency: request cycle + 3 cycles to pN_rvalid_o (IDLE latch, ISSUE accept, response registered).
- Back-to-back:
  - After completion the FSM returns to IDLE.
  - A requester must drop req the cycle after its rvalid.
  - A req still high after that is treated as a new request.
- Request attributes are latched in IDLE. Requester changes after latching are ignored until completion.
- Responses arriving in IDLE or ISSUE with no accept are ignored.
- Reset mid-transaction aborts immediately: no rvalid pulse, all outputs 0. An in-flight memory response after reset release is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE and WAIT_RSP.
  - On reaching TIMEOUT_CYC without completion: pulse the owner's rvalid with rdata=32'hDEAD_BEEF, set err_o (sticky until reset), return to IDLE.
  - The counter clears on every state entry.
- Undefined: no counter; the FSM waits indefinitely; err_o=0.

Test Plan:
- Single read port 0: p0_req, addr=0x0000_0100, mem_ready immediate, rvalid 1 cycle later with 0x1234_5678 -> p0_rvalid_o one cycle with p0_rdata_o=0x1234_5678; stall_o high through the request, low in the rvalid cycle.
- Simultaneous requests: p0 and p1 both held, p1 never dropped, p0 re-requesting continuously -> port 0 wins 8 times, 9th grant to port 1; count clears.
- Write with backpressure: p1 write addr=0x7000, wdata=0xA5, mem_ready low 3 cycles -> mem_req_o/mem_addr_o/mem_wdata_o stable for all 4 ISSUE cycles; p1_rvalid_o after ack.
- Same-cycle ready and rvalid in ISSUE -> completion pulse the next cycle; FSM back in IDLE; no extra mem_req_o.
- Reset asserted in WAIT_RSP -> outputs 0 asynchronously; a later mem_rvalid_i with no request produces no pN_rvalid_o.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=16, memory never responds -> p0_rvalid_o with 0xDEAD_BEEF 16 cycles after the ISSUE entry; err_o stays 1.

Source files
------------

// File: rtl/lsu_mem_arbiter.sv
`default_nettype none
// lsu_mem_arbiter: one-outstanding arbiter of the data-memory bus between the pipeline (port 0)
// and a loader/debug master (port 1). Optional macro ARB_TIMEOUT_EN adds a response watchdog.
module lsu_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8,
   parameter int TIMEOUT_CYC  = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic              p0_req_i,
   input  logic              p0_we_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_wdata_i,
   output logic              p0_rvalid_o,
   output logic [DATA_W-1:0] p0_rdata_o,
   output logic              stall_o,

   input  logic              p1_req_i,
   input  logic              p1_we_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_wdata_i,
   output logic              p1_rvalid_o,
   output logic [DATA_W-1:0] p1_rdata_o,

   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,

   output logic              err_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   localparam int              SC_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("lsu_mem_arbiter: STARVE_LIMIT or TIMEOUT_CYC out of range");
   end

   state_t            state;
   logic              owner;
   logic [SC_W-1:0]   starve_cnt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              arb_en;
   logic              pick_p1;
   logic              tmo_fire;
   logic              done;
   logic [DATA_W-1:0] done_data;

   // The rvalid cycle is dead for arbitration: requesters still hold req while they see rvalid.
   assign arb_en  = (p0_req_i | p1_req_i) & ~p0_rvalid_o & ~p1_rvalid_o;
   assign pick_p1 = p1_req_i & (~p0_req_i | (starve_cnt == SC_MAX));
   assign stall_o = rst_ni & p0_req_i & ~p0_rvalid_o;

   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   always_comb begin
      done      = 1'b0;
      done_data = mem_rdata_i;
      case (state)
         ISSUE:    done = mem_ready_i & mem_rvalid_i;
         WAIT_RSP: done = mem_rvalid_i;
         default:  done = 1'b0;
      endcase
      if (tmo_fire) begin
         done      = 1'b1;
         done_data = DATA_W'(32'hDEAD_BEEF);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         owner       <= 1'b0;
         starve_cnt  <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_req_o   <= 1'b0;
         p0_rvalid_o <= 1'b0;
         p1_rvalid_o <= 1'b0;
         p0_rdata_o  <= '0;
         p1_rdata_o  <= '0;
      end else begin
         p0_rvalid_o <= 1'b0;
         p1_rvalid_o <= 1'b0;
         if (done) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            if (owner) begin
               p1_rvalid_o <= 1'b1;
               p1_rdata_o  <= done_data;
            end else begin
               p0_rvalid_o <= 1'b1;
               p0_rdata_o  <= done_data;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (!p1_req_i) starve_cnt <= '0;
                  if (arb_en) begin
                     owner     <= pick_p1;
                     mem_req_o <= 1'b1;
                     state     <= ISSUE;
                     if (pick_p1) begin
                        we_q       <= p1_we_i;
                        addr_q     <= p1_addr_i;
                        wdata_q    <= p1_wdata_i;
                        starve_cnt <= '0;
                     end else begin
                        we_q    <= p0_we_i;
                        addr_q  <= p0_addr_i;
                        wdata_q <= p0_wdata_i;
                        if (p1_req_i && starve_cnt != SC_MAX) starve_cnt <= starve_cnt + 1'b1;
                     end
                  end
               end
               ISSUE: begin
                  if (mem_ready_i) begin
                     state     <= WAIT_RSP;
                     mem_req_o <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TC_W = $clog2(TIMEOUT_CYC + 1);

   logic [TC_W-1:0] tmo_cnt;
   logic            tmo_err;

   // Counter restarts on every state entry, so the limit applies per state.
   assign tmo_fire = (tmo_cnt == TC_W'(TIMEOUT_CYC - 1)) &
                     (((state == ISSUE) & ~mem_ready_i) | ((state == WAIT_RSP) & ~mem_rvalid_i));
   assign err_o    = tmo_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt <= '0;
         tmo_err <= 1'b0;
      end else begin
         if (tmo_fire) tmo_err <= 1'b1;
         if (state == IDLE || (state == ISSUE && mem_ready_i) || tmo_fire) tmo_cnt <= '0;
         else tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_fire = 1'b0;
   assign err_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_arbiter.sv
`default_nettype none
// tb_lsu_mem_arbiter: directed stimulus with a response scoreboard for lsu_mem_arbiter.
module tb_lsu_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
   logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
   logic        p0_rvalid_o, p1_rvalid_o, stall_o;
   logic [31:0] p0_rdata_o, p1_rdata_o;
   logic        mem_req_o, mem_we_o, mem_ready_i, mem_rvalid_i, err_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   always #5 clk = ~clk;

   lsu_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8), .TIMEOUT_CYC(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
      .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o), .stall_o(stall_o),
      .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
      .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .err_o(err_o)
   );

   typedef struct packed {
      logic        port;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] mon_rd;
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every completion pulse is matched against the oldest expected response.
   always @(negedge clk) begin
      if (rst_ni && (p0_rvalid_o || p1_rvalid_o)) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rvalid: p0=%0b p1=%0b with nothing expected", p0_rvalid_o, p1_rvalid_o);
         end else begin
            mon_e  = sb.pop_front();
            mon_rd = mon_e.port ? p1_rdata_o : p0_rdata_o;
            if ((p0_rvalid_o && p1_rvalid_o) || (p1_rvalid_o !== mon_e.port) ||
                (mon_e.chk_data && mon_rd !== mon_e.data)) begin
               n_fail++;
               $display("FAIL rsp_compare: got p0=%0b p1=%0b data=%h expected port=%0d data=%h",
                        p0_rvalid_o, p1_rvalid_o, mon_rd, mon_e.port, mon_e.data);
            end
         end
      end
   end

   // Memory model
   int          ready_delay = 0;
   bit          same_cycle  = 0;
   bit          rsp_en      = 1;
   bit          ready_en    = 1;
   bit          rsp_manual  = 0;
   bit          pending     = 0;
   int          wait_cnt    = 0;
   logic [31:0] rsp_val;

   function automatic logic [31:0] rdata_for(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h1234_5678;
      return a ^ 32'hC0DE_0000;
   endfunction

   initial begin
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      forever begin
         @(negedge clk);
         if (!rsp_manual) begin
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b0;
            if (pending) begin
               if (rsp_en) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = rsp_val;
               end
               pending = 0;
            end else if (mem_req_o && ready_en) begin
               if (wait_cnt == ready_delay) begin
                  mem_ready_i = 1'b1;
                  wait_cnt    = 0;
                  rsp_val     = mem_we_o ? 32'h0 : rdata_for(mem_addr_o);
                  if (same_cycle) begin
                     mem_rvalid_i = 1'b1;
                     mem_rdata_i  = rsp_val;
                  end else begin
                     pending = 1;
                  end
               end else begin
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
            end
         end
      end
   end

   task automatic wait_rv(input bit port, input int max, output int lat);
      bit seen;
      seen = 0;
      lat  = 0;
      while (!seen && lat < max) begin
         @(negedge clk);
         lat++;
         seen = port ? p1_rvalid_o : p0_rvalid_o;
      end
      if (!seen) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no rvalid within %0d cycles", port ? "p1_wait" : "p0_wait", max);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int lat, p0_wins, n_issue;
   bit p1_seen, any_bad;

   initial begin
      rst_ni     = 1'b0;
      p0_req_i   = 0; p0_we_i = 0; p0_addr_i = '0; p0_wdata_i = '0;
      p1_req_i   = 0; p1_we_i = 0; p1_addr_i = '0; p1_wdata_i = '0;
      repeat (2) @(negedge clk);
      chk("reset_ctrl", {mem_req_o, p0_rvalid_o, p1_rvalid_o, stall_o, err_o, mem_we_o}, 0);
      chk("reset_data", {mem_addr_o, p0_rdata_o, p1_rdata_o}, 0);
      rst_ni = 1'b1;
      @(negedge clk);

      // Single port-0 read
      p0_addr_i = 32'h0000_0100; p0_we_i = 0; p0_req_i = 1;
      sb.push_back('{1'b0, 1'b1, 32'h1234_5678});
      #1 chk("t1_stall_rise", stall_o, 1);
      @(negedge clk);
      chk("t1_issue", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 32'h0000_0100});
      chk("t1_stall_hold", stall_o, 1);
      wait_rv(0, 10, lat);
      chk("t1_latency", lat + 1, 3);
      chk("t1_stall_rvalid", stall_o, 0);
      p0_req_i = 0;
      @(negedge clk);
      chk("t1_pulse_width", p0_rvalid_o, 0);
      @(negedge clk);

      // Starvation: two rounds with both ports holding req
      for (int r = 0; r < 2; r++) begin
         p0_wins = 0; p1_seen = 0;
         p0_addr_i = 32'h10; p1_addr_i = 32'h20; p0_we_i = 0; p1_we_i = 0;
         for (int k = 0; k < 8; k++) sb.push_back('{1'b0, 1'b1, 32'hC0DE_0010});
         sb.push_back('{1'b1, 1'b1, 32'hC0DE_0020});
         p0_req_i = 1; p1_req_i = 1;
         for (int c = 0; c < 100 && !p1_seen; c++) begin
            @(negedge clk);
            if (p0_rvalid_o) p0_wins++;
            if (p1_rvalid_o) p1_seen = 1;
         end
         p0_req_i = 0; p1_req_i = 0;
         chk("t2_p1_granted", p1_seen, 1);
         chk("t2_p0_wins", p0_wins, 8);
         repeat (2) @(negedge clk);
      end

      // Port-1 write with 3 cycles of backpressure; requester changes after latching
      ready_delay = 3;
      p1_we_i = 1; p1_addr_i = 32'h7000; p1_wdata_i = 32'hA5; p1_req_i = 1;
      sb.push_back('{1'b1, 1'b0, 32'h0});
      n_issue = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_req_o) begin
            n_issue++;
            chk("t3_issue_hold", {mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, 32'h7000, 32'hA5});
            p1_addr_i = 32'h7777; p1_wdata_i = 32'hFF; p1_we_i = 0;
         end else if (n_issue > 0) begin
            break;
         end
      end
      chk("t3_issue_cycles", n_issue, 4);
      wait_rv(1, 10, lat);
      p1_req_i = 0; ready_delay = 0;
      repeat (2) @(negedge clk);

      // Ready and response in the same ISSUE cycle
      same_cycle = 1;
      p0_we_i = 0; p0_addr_i = 32'h44; p0_req_i = 1;
      sb.push_back('{1'b0, 1'b1, 32'hC0DE_0044});
      wait_rv(0, 10, lat);
      chk("t4_latency", lat, 2);
      chk("t4_req_dropped", mem_req_o, 0);
      p0_req_i = 0;
      any_bad = 0;
      repeat (4) begin
         @(negedge clk);
         any_bad |= mem_req_o;
      end
      chk("t4_no_extra_req", any_bad, 0);
      same_cycle = 0;

      // Reset while waiting for a response
      rsp_en = 0;
      p1_we_i = 0; p1_addr_i = 32'h88; p1_req_i = 1;
      repeat (2) @(negedge clk);
      chk("t5_pre_reset_addr", mem_addr_o, 32'h88);
      #2 rst_ni = 0;
      #1;
      chk("t5_async_ctrl", {mem_req_o, p0_rvalid_o, p1_rvalid_o, stall_o, err_o}, 0);
      chk("t5_async_data", {mem_addr_o, p0_rdata_o}, 0);
      p1_req_i = 0;
      @(negedge clk);
      rst_ni = 1; rsp_en = 1;
      rsp_manual = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0000;
      @(negedge clk);
      mem_rvalid_i = 0; rsp_manual = 0;
      any_bad = 0;
      repeat (3) begin
         @(negedge clk);
         any_bad |= p0_rvalid_o | p1_rvalid_o;
      end
      chk("t5_stray_rsp_ignored", any_bad, 0);

      // Memory never accepts
      ready_en = 0;
      p0_we_i = 0; p0_addr_i = 32'h200; p0_req_i = 1;
`ifdef ARB_TIMEOUT_EN
      sb.push_back('{1'b0, 1'b1, 32'hDEAD_BEEF});
`endif
      @(negedge clk);
      chk("t6_issue", mem_req_o, 1);
`ifdef ARB_TIMEOUT_EN
      wait_rv(0, 30, lat);
      chk("t6_timeout_latency", lat, 16);
      chk("t6_err_set", err_o, 1);
      p0_req_i = 0;
      repeat (3) @(negedge clk);
      chk("t6_err_sticky", {err_o, mem_req_o}, {1'b1, 1'b0});
      rst_ni = 0;
      #1 chk("t6_err_reset", err_o, 0);
`else
      repeat (40) @(negedge clk);
      chk("t6_no_err", err_o, 0);
      chk("t6_still_waiting", {mem_req_o, stall_o}, {1'b1, 1'b1});
      p0_req_i = 0;
      rst_ni = 0;
      #1 chk("t6_abort", mem_req_o, 0);
`endif
      @(negedge clk);
      rst_ni = 1; ready_en = 1;

      for (int c = 0; c < 10 && sb.size() != 0; c++) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
